// File: rtl/fifo_stream_pkg.sv
// ---------------------------------------------------------------------------
// fifo_stream_pkg
// Shared types and constants for the syn_fifo read-side streamer.
//   state_t            : streamer FSM state (IDLE / ACTIVE / DRAIN)
//   DEFAULT_DATA_WIDTH : default beat width
//   DEFAULT_CNT_WIDTH  : default accepted-beat counter width
//   SKID_DEPTH         : skid buffer entries (covers one cycle of read latency
//                        plus one beat held under backpressure)
//   fill_after()       : skid occupancy after this cycle's push/pop
// ---------------------------------------------------------------------------
package fifo_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 16;
  localparam int SKID_DEPTH         = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Occupancy never exceeds SKID_DEPTH (2), so two bits are enough.
  function automatic logic [1:0] fill_after(input logic [1:0] occ,
                                            input logic       push,
                                            input logic       pop);
    return occ + {1'b0, push} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// ---------------------------------------------------------------------------
// fifo_skid_buf
// Two-entry ring buffer that catches FIFO read data arriving one cycle after
// the read was issued and presents it in strict arrival order.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset (clears contents)
//   i_push       in   write i_push_data this cycle
//   i_push_data  in   data to store
//   i_pop        in   retire the oldest entry this cycle
//   o_head_data  out  oldest entry (0 after reset)
//   o_occ        out  number of valid entries, 0..2
// ---------------------------------------------------------------------------
module fifo_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic [1:0]            o_occ
);

  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;

  // NOTE: the storage is only two entries, so it is reset along with the
  // pointers; this discards stale beats on reset and makes the head read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // pointer values, so push and pop in the same cycle don't interfere.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= fill_after(r_occ, i_push, i_pop);
    end
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_occ       = r_occ;

  // Upstream issue logic guarantees these never happen.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_pop && (r_occ == 2'(SKID_DEPTH))));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(i_pop && (r_occ == 2'd0)));

endmodule

// File: rtl/fifo_rd_streamer.sv
// ---------------------------------------------------------------------------
// fifo_rd_streamer
// Drains syn_fifo into a valid/ready stream. Reads are issued only when the
// skid buffer is guaranteed to have room for the data one cycle later, which
// sustains one beat per cycle while never overflowing under backpressure.
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset (shared with syn_fifo)
//   en             in   0 stops new reads; data already in flight still drains
//   fifo_empty     in   syn_fifo empty flag
//   fifo_data_out  in   syn_fifo read data, valid the cycle after a read
//   fifo_rd_cs     out  syn_fifo read chip select (same as fifo_rd_en)
//   fifo_rd_en     out  syn_fifo read enable
//   m_valid        out  output beat valid
//   m_data         out  output beat data, oldest buffered entry
//   m_ready        in   downstream accept
//   busy           out  read in flight or buffered data present
//   beat_cnt       out  accepted beats, wraps at 2^CNT_WIDTH
// Timing: read issued in cycle t -> data lands end of t+1 -> m_valid in t+2.
// ---------------------------------------------------------------------------
module fifo_rd_streamer
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  state_t               r_state;
  logic                 r_busy;
  logic                 r_pend;
  logic [CNT_WIDTH-1:0] r_beat_cnt;

  logic       w_pop;
  logic       w_issue;
  logic [1:0] w_occ;
  logic [1:0] w_occ_next;

  // -------------------------------------------------------------------------
  // Skid buffer: every completed read (r_pend) lands here.
  // -------------------------------------------------------------------------
  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_pend),
    .i_push_data (fifo_data_out),
    .i_pop       (w_pop),
    .o_head_data (m_data),
    .o_occ       (w_occ)
  );

  assign m_valid    = (w_occ != 2'd0);
  assign w_pop      = m_valid & m_ready;
  assign w_occ_next = fill_after(w_occ, r_pend, w_pop);

  // A read issued now lands next cycle on top of w_occ_next entries, so it
  // is only safe while w_occ_next leaves a free slot. Counting this cycle's
  // pop keeps the pipe full at one beat per cycle under m_ready=1.
  assign w_issue = ~rst & en & ~fifo_empty & (w_occ_next < 2'(SKID_DEPTH));

  assign fifo_rd_cs = w_issue;
  assign fifo_rd_en = w_issue;

  // -------------------------------------------------------------------------
  // Read-in-flight flag, FSM and beat counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_pend <= w_issue;

      if (w_pop) begin
        r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
      end

      // r_busy mirrors (next state != IDLE) so busy comes straight from a flop.
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state <= ACTIVE;
            r_busy  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!w_issue) begin
            // Going fully idle takes priority over draining when the last
            // buffered beat leaves this very cycle.
            if (!r_pend && (w_occ_next == 2'd0)) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (r_pend || (w_occ != 2'd0)) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_issue) begin
            r_state <= ACTIVE;
          end else if (!r_pend && (w_occ_next == 2'd0)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign beat_cnt = r_beat_cnt;

  // -------------------------------------------------------------------------
  // Simulation checks on the invariants the issue logic relies on.
  // -------------------------------------------------------------------------
  a_skid_bound : assert property (@(posedge clk) disable iff (rst)
    (({1'b0, w_occ} + {2'b00, r_pend}) <= 3'(SKID_DEPTH)));
  a_no_read_when_empty : assert property (@(posedge clk) disable iff (rst)
    !(fifo_rd_en && fifo_empty));
  a_busy_matches_state : assert property (@(posedge clk) disable iff (rst)
    (busy == (r_state != IDLE)));
  a_data_held : assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_streamer
// Directed bench for fifo_rd_streamer driving a behavioural syn_fifo model
// (registered read data, empty flag, cleared by the shared reset). The DUT
// uses CNT_WIDTH=4 so beat counter wrap is reachable quickly.
// ---------------------------------------------------------------------------
module tb_fifo_rd_streamer;
  import fifo_stream_pkg::*;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_rd_cs;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          busy;
  logic [CW-1:0] beat_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_rd_streamer #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_cs    (fifo_rd_cs),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .busy          (busy),
    .beat_cnt      (beat_cnt)
  );

  // ---------------- syn_fifo model ----------------
  logic [7:0] fmem [0:255];
  logic [7:0] wr_cnt = 8'd0;
  logic [7:0] rd_ptr;

  assign fifo_empty = (rd_ptr == wr_cnt);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr        <= wr_cnt;
      fifo_data_out <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= fmem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
  end

  // ---------------- stream monitor ----------------
  logic [7:0] beats [0:511];
  int nb  = 0;
  int nrd = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        beats[nb] = m_data;
        nb = nb + 1;
      end
      if (fifo_rd_en) nrd = nrd + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    fmem[wr_cnt] = d;
    wr_cnt = wr_cnt + 8'd1;
  endtask

  // Cycle tables for the 4-entry burst (cycle 0 = first issue).
  int exp_rd [7] = '{1, 1, 1, 1, 0, 0, 0};
  int exp_v  [7] = '{0, 0, 1, 1, 1, 1, 0};
  int exp_d  [7] = '{0, 0, 'h11, 'h12, 'h13, 'h14, 0};
  int exp_b  [7] = '{0, 1, 1, 1, 1, 1, 0};

  int b0;
  int r0;

  initial begin
    // ---------- reset state ----------
    #2;
    check("rst_m_valid",  32'(m_valid),    32'd0);
    check("rst_m_data",   32'(m_data),     32'd0);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_beat_cnt", 32'(beat_cnt),   32'd0);
    check("rst_rd_en",    32'(fifo_rd_en), 32'd0);
    check("rst_rd_cs",    32'(fifo_rd_cs), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_no_issue", 32'(fifo_rd_en), 32'd0);
    en = 1'b1;
    #1;
    check("empty_no_issue", 32'(fifo_rd_en), 32'd0);

    // ---------- 4-entry burst, m_ready=1 ----------
    tick();
    m_ready = 1'b1;
    load(8'h11); load(8'h12); load(8'h13); load(8'h14);
    #1;
    for (int c = 0; c < 7; c++) begin
      check($sformatf("burst_rd_en_c%0d", c), 32'(fifo_rd_en), 32'(exp_rd[c]));
      check($sformatf("burst_valid_c%0d", c), 32'(m_valid), 32'(exp_v[c]));
      if (exp_v[c] != 0)
        check($sformatf("burst_data_c%0d", c), 32'(m_data), 32'(exp_d[c]));
      check($sformatf("burst_busy_c%0d", c), 32'(busy), 32'(exp_b[c]));
      tick();
    end

    // ---------- single entry ----------
    for (int c = 0; c < 3; c++) begin
      check("empty_hold_rd_en", 32'(fifo_rd_en), 32'd0);
      tick();
    end
    b0 = nb;
    r0 = nrd;
    load(8'hA5);
    repeat (6) tick();
    check("single_reads", 32'(nrd - r0), 32'd1);
    check("single_beats", 32'(nb - b0),  32'd1);
    check("single_data",  32'(beats[b0]), 32'hA5);
    check("single_busy",  32'(busy),      32'd0);
    check("single_rd_en", 32'(fifo_rd_en), 32'd0);

    // ---------- backpressure after first beat ----------
    b0 = nb;
    r0 = nrd;
    for (int i = 0; i < 8; i++) load(8'(8'h20 + i));
    #1;
    check("bp_first_issue", 32'(fifo_rd_en), 32'd1);
    tick();
    tick();
    check("bp_first_valid", 32'(m_valid), 32'd1);
    check("bp_first_data",  32'(m_data),  32'h20);
    tick();
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_hold_valid", 32'(m_valid),    32'd1);
      check("bp_hold_data",  32'(m_data),     32'h21);
      check("bp_hold_rd_en", 32'(fifo_rd_en), 32'd0);
      tick();
    end
    check("bp_occ_full", 32'(dut.w_occ), 32'd2);
    check("bp_reads_held", 32'(nrd - r0), 32'd3);
    m_ready = 1'b1;
    repeat (14) tick();
    check("bp_reads_total", 32'(nrd - r0), 32'd8);
    check("bp_beats_total", 32'(nb - b0),  32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("bp_beat%0d", i), 32'(beats[b0 + i]), 32'(8'h20 + i));

    // ---------- en dropped after 5th issue ----------
    en = 1'b0;
    b0 = nb;
    r0 = nrd;
    for (int i = 0; i < 16; i++) load(8'(8'h30 + i));
    en = 1'b1;
    #1;
    check("en_c0_issue", 32'(fifo_rd_en), 32'd1);
    repeat (4) tick();
    check("en_c4_issue", 32'(fifo_rd_en), 32'd1);
    tick();
    en = 1'b0;
    #1;
    check("en_c5_no_issue", 32'(fifo_rd_en), 32'd0);
    tick();
    check("en_c6_drain", 32'(dut.r_state), 32'(DRAIN));
    check("en_c6_busy",  32'(busy),        32'd1);
    tick();
    check("en_c7_idle",  32'(dut.r_state), 32'(IDLE));
    check("en_c7_busy",  32'(busy),        32'd0);
    repeat (4) tick();
    check("en_reads", 32'(nrd - r0), 32'd5);
    check("en_beats", 32'(nb - b0),  32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("en_beat%0d", i), 32'(beats[b0 + i]), 32'(8'h30 + i));
    check("en_no_rd_en", 32'(fifo_rd_en), 32'd0);

    // ---------- reset mid-run ----------
    en = 1'b1;
    tick();
    tick();
    check("mid_streaming", 32'(m_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid",  32'(m_valid),    32'd0);
    check("mid_rst_m_data",   32'(m_data),     32'd0);
    check("mid_rst_busy",     32'(busy),       32'd0);
    check("mid_rst_beat_cnt", 32'(beat_cnt),   32'd0);
    check("mid_rst_rd_en",    32'(fifo_rd_en), 32'd0);
    check("mid_rst_rd_cs",    32'(fifo_rd_cs), 32'd0);
    tick();
    rst = 1'b0;
    en = 1'b0;
    #1;
    check("post_rst_no_issue", 32'(fifo_rd_en), 32'd0);
    b0 = nb;
    load(8'h5A);
    #1;
    check("post_rst_en0", 32'(fifo_rd_en), 32'd0);
    en = 1'b1;
    #1;
    check("post_rst_en1", 32'(fifo_rd_en), 32'd1);
    repeat (4) tick();
    check("post_rst_beats", 32'(nb - b0),   32'd1);
    check("post_rst_data",  32'(beats[b0]), 32'h5A);
    check("post_rst_cnt",   32'(beat_cnt),  32'd1);

    // ---------- beat counter wrap (CNT_WIDTH=4) ----------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("wrap_cnt_start", 32'(beat_cnt), 32'd0);
    b0 = nb;
    for (int i = 0; i < 17; i++) load(8'(8'h40 + i));
    repeat (25) tick();
    check("wrap_beats", 32'(nb - b0), 32'd17);
    check("wrap_cnt",   32'(beat_cnt), 32'd1);
    m_ready = 1'b0;
    load(8'h99);
    repeat (4) tick();
    check("stall_valid", 32'(m_valid),  32'd1);
    check("stall_data",  32'(m_data),   32'h99);
    check("stall_cnt",   32'(beat_cnt), 32'd1);
    tick();
    check("stall_cnt2",  32'(beat_cnt), 32'd1);
    m_ready = 1'b1;
    tick();
    check("accept_cnt",  32'(beat_cnt), 32'd2);
    check("accept_empty", 32'(m_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
